// File: rtl/coef_block_writer.sv
// coef_block_writer: sink end of the coefficient pipeline.
// Collects 64 raster-order coefficients per 8x8 block and writes each one into
// a ping-pong output BRAM (two 64-word banks) at its zigzag position. A completed
// bank is handed to the entropy stage by setting its ownership flag, and the
// upstream pipeline is stalled through in_ready_o while the next bank is still
// owned by the downstream reader.
module coef_block_writer #(
    parameter int DATA_W    = 12,
    parameter bit ZIGZAG_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ce_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              bram_we_o,
    output logic [6:0]        bram_addr_o,
    output logic [DATA_W-1:0] bram_wdata_o,
    output logic              blk_done_o,
    output logic              blk_bank_o,
    input  logic              rd_release_i,
    input  logic              rd_bank_i,
    output logic [1:0]        bank_full_o,
    output logic              err_release_o
);

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam logic [5:0] LAST_IDX = 6'd63;

    // Raster position -> zigzag position of an 8x8 block (a permutation of 0..63).
    function automatic logic [5:0] zz_index(input logic [5:0] raster);
        zz_index = 6'd0;
        case (raster)
            6'd0:  zz_index = 6'd0;
            6'd1:  zz_index = 6'd1;
            6'd2:  zz_index = 6'd5;
            6'd3:  zz_index = 6'd6;
            6'd4:  zz_index = 6'd14;
            6'd5:  zz_index = 6'd15;
            6'd6:  zz_index = 6'd27;
            6'd7:  zz_index = 6'd28;
            6'd8:  zz_index = 6'd2;
            6'd9:  zz_index = 6'd4;
            6'd10: zz_index = 6'd7;
            6'd11: zz_index = 6'd13;
            6'd12: zz_index = 6'd16;
            6'd13: zz_index = 6'd26;
            6'd14: zz_index = 6'd29;
            6'd15: zz_index = 6'd42;
            6'd16: zz_index = 6'd3;
            6'd17: zz_index = 6'd8;
            6'd18: zz_index = 6'd12;
            6'd19: zz_index = 6'd17;
            6'd20: zz_index = 6'd25;
            6'd21: zz_index = 6'd30;
            6'd22: zz_index = 6'd41;
            6'd23: zz_index = 6'd43;
            6'd24: zz_index = 6'd9;
            6'd25: zz_index = 6'd11;
            6'd26: zz_index = 6'd18;
            6'd27: zz_index = 6'd24;
            6'd28: zz_index = 6'd31;
            6'd29: zz_index = 6'd40;
            6'd30: zz_index = 6'd44;
            6'd31: zz_index = 6'd53;
            6'd32: zz_index = 6'd10;
            6'd33: zz_index = 6'd19;
            6'd34: zz_index = 6'd23;
            6'd35: zz_index = 6'd32;
            6'd36: zz_index = 6'd39;
            6'd37: zz_index = 6'd45;
            6'd38: zz_index = 6'd52;
            6'd39: zz_index = 6'd54;
            6'd40: zz_index = 6'd20;
            6'd41: zz_index = 6'd22;
            6'd42: zz_index = 6'd33;
            6'd43: zz_index = 6'd38;
            6'd44: zz_index = 6'd46;
            6'd45: zz_index = 6'd51;
            6'd46: zz_index = 6'd55;
            6'd47: zz_index = 6'd60;
            6'd48: zz_index = 6'd21;
            6'd49: zz_index = 6'd34;
            6'd50: zz_index = 6'd37;
            6'd51: zz_index = 6'd47;
            6'd52: zz_index = 6'd50;
            6'd53: zz_index = 6'd56;
            6'd54: zz_index = 6'd59;
            6'd55: zz_index = 6'd61;
            6'd56: zz_index = 6'd35;
            6'd57: zz_index = 6'd36;
            6'd58: zz_index = 6'd48;
            6'd59: zz_index = 6'd49;
            6'd60: zz_index = 6'd57;
            6'd61: zz_index = 6'd58;
            6'd62: zz_index = 6'd62;
            6'd63: zz_index = 6'd63;
            default: zz_index = 6'd0;
        endcase
    endfunction

    // Control state
    logic [0:0]        state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [1:0]        bank_full_q, bank_full_d;

    // Registered write port and status pulses
    logic              we_q, we_d;
    logic [6:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              blk_bank_q, blk_bank_d;
    logic              err_q, err_d;

    // Handshake and bank bookkeeping terms
    logic              accept;
    logic              last_accept;
    logic [5:0]        wr_index;
    logic [1:0]        set_mask;
    logic [1:0]        rel_mask;
    logic              rel_hit;

    // Ready depends only on registered state and ce, never on in_valid_i.
    assign in_ready_o  = (state_q == ST_FILL) && ce_i;
    assign accept      = ce_i && in_valid_i && in_ready_o;
    assign last_accept = accept && (cnt_q == LAST_IDX);
    assign wr_index    = ZIGZAG_EN ? zz_index(cnt_q) : cnt_q;

    assign set_mask = last_accept  ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
    assign rel_mask = rd_release_i ? (rd_bank_i ? 2'b10 : 2'b01) : 2'b00;
    // A release only counts when the target is full; a bank being completed on
    // this edge is by construction not full, so a same-bank release is an error.
    assign rel_hit  = |(rel_mask & bank_full_q);

    // FSM, block counter and bank pointer next state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_bank_d = wr_bank_q;
        case (state_q)
            ST_WAIT: begin
                // One bubble cycle per block, spent checking the bank is free.
                if (!bank_full_q[wr_bank_q]) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d   = ST_WAIT;
                        cnt_d     = 6'd0;
                        wr_bank_d = ~wr_bank_q;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Write port, completion pulse and bank ownership next state.
    always_comb begin
        we_d        = accept;
        addr_d      = accept ? {wr_bank_q, wr_index} : addr_q;
        wdata_d     = accept ? in_data_i : wdata_q;
        done_d      = last_accept;
        blk_bank_d  = last_accept ? wr_bank_q : blk_bank_q;
        // Clear first, then set: on a same-bank collision the set wins.
        bank_full_d = (bank_full_q & ~rel_mask) | set_mask;
        err_d       = rd_release_i && !rel_hit;
    end

    // State registers; with ce_i low everything freezes, including pending pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_WAIT;
            wr_bank_q   <= 1'b0;
            cnt_q       <= 6'd0;
            bank_full_q <= 2'b00;
            we_q        <= 1'b0;
            addr_q      <= 7'd0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            blk_bank_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (ce_i) begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            cnt_q       <= cnt_d;
            bank_full_q <= bank_full_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            blk_bank_q  <= blk_bank_d;
            err_q       <= err_d;
        end
    end

    // Pulses are masked while stalled; a write held across a ce_i-low stretch
    // is presented once when the pipeline resumes, so it is neither lost nor doubled.
    assign bram_we_o     = we_q && ce_i;
    assign blk_done_o    = done_q && ce_i;
    assign err_release_o = err_q && ce_i;
    assign bram_addr_o   = addr_q;
    assign bram_wdata_o  = wdata_q;
    assign blk_bank_o    = blk_bank_q;
    assign bank_full_o   = bank_full_q;

endmodule

// File: tb/tb_coef_block_writer.sv
// Testbench for coef_block_writer: a zigzag instance and a raster-bypass
// instance share one stimulus stream; writes are logged and compared against
// hand-computed vectors and an independently generated zigzag map.
module tb_coef_block_writer;

    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              rd_release;
    logic              rd_bank;

    logic              in_ready, bram_we, blk_done, blk_bank, err_release;
    logic [6:0]        bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [1:0]        bank_full;

    logic              in_ready_r, bram_we_r, blk_done_r, blk_bank_r, err_release_r;
    logic [6:0]        bram_addr_r;
    logic [DATA_W-1:0] bram_wdata_r;
    logic [1:0]        bank_full_r;

    coef_block_writer #(.DATA_W(DATA_W), .ZIGZAG_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
        .bram_wdata_o(bram_wdata), .blk_done_o(blk_done), .blk_bank_o(blk_bank),
        .rd_release_i(rd_release), .rd_bank_i(rd_bank), .bank_full_o(bank_full),
        .err_release_o(err_release)
    );

    coef_block_writer #(.DATA_W(DATA_W), .ZIGZAG_EN(1'b0)) dut_raw (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready_r), .bram_we_o(bram_we_r), .bram_addr_o(bram_addr_r),
        .bram_wdata_o(bram_wdata_r), .blk_done_o(blk_done_r), .blk_bank_o(blk_bank_r),
        .rd_release_i(rd_release), .rd_bank_i(rd_bank), .bank_full_o(bank_full_r),
        .err_release_o(err_release_r)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int wr_n = 0, wr_n_r = 0, hs_n = 0, err_n = 0, done_n = 0;
    int mem [128];
    int mem_r [128];
    int log_addr [2048];
    int log_data [2048];
    int log_cyc [2048];
    logic log_done [2048];
    logic log_bank [2048];
    int zz_tb [64];

    typedef struct {
        int         raster;
        logic [6:0] exp_addr;
    } vec_t;
    vec_t vecs [10];

    // Cycle counter, advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Write/pulse monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (bram_we) begin
            if (wr_n < 2048) begin
                log_addr[wr_n] <= int'(bram_addr);
                log_data[wr_n] <= int'(bram_wdata);
                log_cyc[wr_n]  <= cyc;
                log_done[wr_n] <= blk_done;
                log_bank[wr_n] <= blk_bank;
            end
            mem[bram_addr] <= int'(bram_wdata);
            wr_n <= wr_n + 1;
        end
        if (bram_we_r) begin
            mem_r[bram_addr_r] <= int'(bram_wdata_r);
            wr_n_r <= wr_n_r + 1;
        end
        if (blk_done) done_n <= done_n + 1;
        if (err_release) err_n <= err_n + 1;
        if (ce && in_valid && in_ready) hs_n <= hs_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string p, input logic rdy, input logic we,
                              input logic [6:0] addr, input logic [DATA_W-1:0] wd,
                              input logic done, input logic bank, input logic [1:0] full,
                              input logic err);
        check({p, "_in_ready"}, 32'(rdy), 0);
        check({p, "_bram_we"}, 32'(we), 0);
        check({p, "_bram_addr"}, 32'(addr), 0);
        check({p, "_bram_wdata"}, 32'(wd), 0);
        check({p, "_blk_done"}, 32'(done), 0);
        check({p, "_blk_bank"}, 32'(bank), 0);
        check({p, "_bank_full"}, 32'(full), 0);
        check({p, "_err_release"}, 32'(err), 0);
    endtask

    // Offers samples base+start .. base+start+count-1; called and returns at posedge+1.
    task automatic stream(input int base, input int start, input int count, input int duty);
        int   sent = 0;
        int   budget = 0;
        logic acc;
        while (sent < count && budget < 2000) begin
            in_data  = DATA_W'(base + start + sent);
            in_valid = ($urandom_range(0, 99) < duty);
            @(negedge clk);
            acc = ce && in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            budget++;
        end
        in_valid = 1'b0;
        if (sent < count) check("stream_budget", sent, count);
    endtask

    // Lets the monitor log the write produced by the last edge.
    task automatic settle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank(input string name, input bit raw, input int bank, input int base);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            int pos;
            int exp;
            int got;
            pos = raw ? i : zz_tb[i];
            exp = (base + i) % 4096;
            got = raw ? mem_r[bank * 64 + pos] : mem[bank * 64 + pos];
            if (got != exp) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ce         = 1'b1;
        in_valid   = 1'b0;
        rd_release = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int w0, w1, d0, e0, h0, r0, wf, wb0, rel_cyc;

        // Zigzag map by walking the anti-diagonals, alternating direction.
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz_tb[r * 8 + (s - r)] = k;
                    k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz_tb[r * 8 + (s - r)] = k;
                    k++;
                end
            end
        end

        vecs[0] = '{0,  7'h00};
        vecs[1] = '{1,  7'h01};
        vecs[2] = '{2,  7'h05};
        vecs[3] = '{3,  7'h06};
        vecs[4] = '{8,  7'h02};
        vecs[5] = '{9,  7'h04};
        vecs[6] = '{10, 7'h07};
        vecs[7] = '{16, 7'h03};
        vecs[8] = '{62, 7'h3E};
        vecs[9] = '{63, 7'h3F};

        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = '0; rd_release = 1'b0; rd_bank = 1'b0;
        #1;
        check_idle("rst", in_ready, bram_we, bram_addr, bram_wdata, blk_done, blk_bank, bank_full, err_release);
        check_idle("rst_raw", in_ready_r, bram_we_r, bram_addr_r, bram_wdata_r, blk_done_r, blk_bank_r,
                   bank_full_r, err_release_r);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First block: one WAIT bubble, then 64 back-to-back writes into bank 0.
        in_valid = 1'b1;
        in_data  = '0;
        @(negedge clk);
        check("t1_wait_bubble_ready", in_ready, 0);
        @(posedge clk);
        #1;
        w0 = wr_n;
        d0 = done_n;
        e0 = err_n;
        stream(0, 0, 64, 100);
        settle();
        check("t1_writes", wr_n - w0, 64);
        check("t1_consecutive", log_cyc[w0 + 63] - log_cyc[w0], 63);
        for (int v = 0; v < 10; v++) begin
            check($sformatf("t1_vec%0d_addr", vecs[v].raster), log_addr[w0 + vecs[v].raster], 32'(vecs[v].exp_addr));
            check($sformatf("t1_vec%0d_data", vecs[v].raster), log_data[w0 + vecs[v].raster], vecs[v].raster);
        end
        check("t1_done_on_last", 32'(log_done[w0 + 63]), 1);
        check("t1_done_bank", 32'(log_bank[w0 + 63]), 0);
        check("t1_done_count", done_n - d0, 1);
        check("t1_bank_full", 32'(bank_full), 2'b01);
        check_bank("t1_bank0_zigzag", 1'b0, 0, 0);
        check_bank("t1_bank0_raw", 1'b1, 0, 0);

        // Second block fills bank 1, third block stalls until bank 0 is released.
        stream(100, 0, 64, 100);
        settle();
        check("t2_bank_full_both", 32'(bank_full), 2'b11);
        check("t2_blk_bank_hold", 32'(blk_bank), 1);
        check_bank("t2_bank1_zigzag", 1'b0, 1, 100);
        w1 = wr_n;
        rel_cyc = 0;
        fork
            stream(200, 0, 64, 100);
            begin
                repeat (10) begin
                    @(posedge clk);
                    #1;
                end
                check("t2_stall_no_write", wr_n - w1, 0);
                check("t2_stall_ready", 32'(in_ready), 0);
                rd_release = 1'b1;
                rd_bank    = 1'b0;
                @(posedge clk);
                #1;
                rel_cyc    = cyc;
                rd_release = 1'b0;
            end
        join
        settle();
        check("t2_resume_latency", log_cyc[w1] - rel_cyc, 2);
        check("t2_resume_addr", log_addr[w1], 0);
        check_bank("t2_bank0_block2", 1'b0, 0, 200);
        check("t2_bank_full_again", 32'(bank_full), 2'b11);
        check("t2_blk_bank", 32'(blk_bank), 0);
        rd_release = 1'b1;
        rd_bank    = 1'b0;
        @(posedge clk);
        #1;
        rd_bank = 1'b1;
        @(posedge clk);
        #1;
        rd_release = 1'b0;
        @(posedge clk);
        #1;
        check("t2_bank_full_freed", 32'(bank_full), 2'b00);
        check("t2_no_err", err_n - e0, 0);

        // Release of a free bank, then releases colliding with a completion.
        do_reset();
        e0 = err_n;
        rd_release = 1'b1;
        rd_bank    = 1'b1;
        @(posedge clk);
        #1;
        rd_release = 1'b0;
        @(negedge clk);
        check("t3_err_pulse", 32'(err_release), 1);
        check("t3_err_full_unchanged", 32'(bank_full), 2'b00);
        @(negedge clk);
        check("t3_err_one_cycle", 32'(err_release), 0);
        @(posedge clk);
        #1;
        check("t3_err_count", err_n - e0, 1);

        stream(300, 0, 63, 100);
        in_valid   = 1'b1;
        in_data    = DATA_W'(300 + 63);
        rd_release = 1'b1;
        rd_bank    = 1'b1;
        @(negedge clk);
        check("t3_ready_last", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rd_release = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        check("t3_diff_done", 32'(blk_done), 1);
        check("t3_diff_err", 32'(err_release), 1);
        check("t3_diff_full", 32'(bank_full), 2'b01);
        @(posedge clk);
        #1;
        check_bank("t3_bank0", 1'b0, 0, 300);

        stream(400, 0, 63, 100);
        in_valid   = 1'b1;
        in_data    = DATA_W'(400 + 63);
        rd_release = 1'b1;
        rd_bank    = 1'b1;
        @(posedge clk);
        #1;
        rd_release = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        check("t3_same_done", 32'(blk_done), 1);
        check("t3_same_bank", 32'(blk_bank), 1);
        check("t3_same_err", 32'(err_release), 1);
        check("t3_same_full", 32'(bank_full), 2'b11);
        @(posedge clk);
        #1;

        // Sparse in_valid: one write per handshake, raster bypass keeps raster order.
        do_reset();
        h0 = hs_n;
        r0 = wr_n_r;
        w0 = wr_n;
        stream(500, 0, 64, 30);
        settle();
        check("t4_handshakes", hs_n - h0, 64);
        check("t4_raw_writes", wr_n_r - r0, 64);
        check("t4_writes", wr_n - w0, 64);
        check_bank("t4_raw_bank0", 1'b1, 0, 500);
        check_bank("t4_zigzag_bank0", 1'b0, 0, 500);
        check("t4_bank_full", 32'(bank_full), 2'b01);

        // Asynchronous reset in the middle of a block.
        stream(600, 0, 20, 100);
        check("t5_pre_we", 32'(bram_we), 1);
        check("t5_pre_full", 32'(bank_full), 2'b01);
        #1;
        rst = 1'b1;
        #1;
        check_idle("t5_async", in_ready, bram_we, bram_addr, bram_wdata, blk_done, blk_bank, bank_full, err_release);
        @(posedge clk);
        #1;
        rst = 1'b0;
        w0 = wr_n;
        stream(700, 0, 64, 100);
        settle();
        check("t5_restart_addr", log_addr[w0], 0);
        check("t5_restart_data", log_data[w0], 700);
        check_bank("t5_bank0", 1'b0, 0, 700);
        check("t5_bank_full", 32'(bank_full), 2'b01);

        // ce low for five cycles at cnt=30, with a release that must be ignored.
        wb0 = wr_n;
        e0  = err_n;
        stream(800, 0, 30, 100);
        in_valid = 1'b1;
        in_data  = DATA_W'(800 + 30);
        ce       = 1'b0;
        wf       = wr_n;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                rd_release = 1'b1;
                rd_bank    = 1'b0;
            end
            @(negedge clk);
            check("t6_frozen_we", 32'(bram_we), 0);
            @(posedge clk);
            #1;
            rd_release = 1'b0;
        end
        check("t6_frozen_writes", wr_n - wf, 0);
        check("t6_frozen_full", 32'(bank_full), 2'b01);
        check("t6_frozen_err", err_n - e0, 0);
        check("t6_frozen_ready", 32'(in_ready), 0);
        ce = 1'b1;
        stream(800, 30, 34, 100);
        settle();
        check("t6_resume_addr", log_addr[wf + 1], 64 + zz_tb[30]);
        check("t6_resume_data", log_data[wf + 1], 830);
        check("t6_block_writes", wr_n - wb0, 64);
        check_bank("t6_bank1", 1'b0, 1, 800);
        check("t6_bank_full", 32'(bank_full), 2'b11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
